// File: rtl/controle_iluminacao_pkg.sv
// Shared types and defaults for the automatic lighting controller.
// Lamp states, press-classifier pulse bundle, default press timings.
package pacote_iluminacao;

    typedef enum logic [1:0] {
        APAGADA      = 2'd0,
        ACESA_AUTO   = 2'd1,
        ACESA_MANUAL = 2'd2
    } estado_luz_t;

    typedef struct packed {
        logic curto;
        logic longo;
    } pulsos_t;

    localparam int MIN_PRESS_T_DEF  = 50;
    localparam int LONG_PRESS_T_DEF = 3000;

endpackage

// File: rtl/controle_iluminacao_classificador.sv
// Push-button press classifier: glitch / short / long.
// Emits one-cycle short pulse on release, one-cycle long pulse at saturation.
module classificador_botao
    import pacote_iluminacao::*;
#(
    parameter int MIN_PRESS_T  = MIN_PRESS_T_DEF,
    parameter int LONG_PRESS_T = LONG_PRESS_T_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    botao,
    output pulsos_t pulsos
);

    localparam int W = $clog2(LONG_PRESS_T + 1);
    localparam logic [W-1:0] MIN_V  = W'(MIN_PRESS_T);
    localparam logic [W-1:0] LONG_V = W'(LONG_PRESS_T);

    logic [W-1:0] tp;
    logic         botao_ant;

    // Hold-time counter, release edge detect and pulse generation
    always_ff @(posedge clk) begin
        if (rst) begin
            tp        <= '0;
            botao_ant <= 1'b0;
            pulsos    <= '0;
        end else begin
            botao_ant <= botao;
            pulsos    <= '0;
            if (botao) begin
                if (tp != LONG_V)
                    tp <= tp + 1'b1;
                pulsos.longo <= (tp == LONG_V - 1'b1);
            end else begin
                tp <= '0;
                if (botao_ant && tp >= MIN_V && tp < LONG_V)
                    pulsos.curto <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/controle_iluminacao.sv
// Lighting sequencer: button classifier plus lamp state machine.
// Drives lamp, shutdown-timer enable and manual-mode flag.
module controle_iluminacao
    import pacote_iluminacao::*;
#(
    parameter int MIN_PRESS_T  = MIN_PRESS_T_DEF,
    parameter int LONG_PRESS_T = LONG_PRESS_T_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    input  logic infravermelho,
    input  logic C,
    output logic L,
    output logic enable,
    output logic modo_manual
);

    pulsos_t     pulsos;
    estado_luz_t estado;
    estado_luz_t prox;

    classificador_botao #(
        .MIN_PRESS_T (MIN_PRESS_T),
        .LONG_PRESS_T(LONG_PRESS_T)
    ) u_classificador (
        .clk   (clk),
        .rst   (rst),
        .botao (botao),
        .pulsos(pulsos)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            estado <= APAGADA;
        else
            estado <= prox;
    end

    // Next state: long press beats short press beats timeout/presence
    always_comb begin
        prox = APAGADA;
        case (estado)
            APAGADA: begin
                if (pulsos.longo)
                    prox = ACESA_MANUAL;
                else if (pulsos.curto || infravermelho)
                    prox = ACESA_AUTO;
                else
                    prox = APAGADA;
            end
            ACESA_AUTO: begin
                if (pulsos.longo)
                    prox = ACESA_MANUAL;
                else if (pulsos.curto || C)
                    prox = APAGADA;
                else
                    prox = ACESA_AUTO;
            end
            ACESA_MANUAL: begin
                if (pulsos.longo)
                    prox = ACESA_AUTO;
                else if (pulsos.curto)
                    prox = APAGADA;
                else
                    prox = ACESA_MANUAL;
            end
            default: prox = APAGADA;
        endcase
    end

    // Moore output decode
    always_comb begin
        L           = 1'b0;
        enable      = 1'b0;
        modo_manual = 1'b0;
        case (estado)
            ACESA_AUTO: begin
                L      = 1'b1;
                enable = 1'b1;
            end
            ACESA_MANUAL: begin
                L           = 1'b1;
                modo_manual = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controle_iluminacao.sv
// Directed bench for the lighting sequencer.
// Short timings: MIN_PRESS_T=2, LONG_PRESS_T=8.
module tb_controle_iluminacao;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic botao = 1'b0;
    logic infravermelho = 1'b0;
    logic C = 1'b0;
    logic L;
    logic enable;
    logic modo_manual;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controle_iluminacao #(
        .MIN_PRESS_T (2),
        .LONG_PRESS_T(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .botao        (botao),
        .infravermelho(infravermelho),
        .C            (C),
        .L            (L),
        .enable       (enable),
        .modo_manual  (modo_manual)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out got %b want 000", {L, enable, modo_manual});
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({L, enable, modo_manual} !== 3'b000) begin
                errors++;
                $display("FAIL idle_%0d got %b want 000", i, {L, enable, modo_manual});
            end
        end
    endtask

    task automatic test_short_press;
        botao = 1'b1;
        step(4);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL short_held_pulse got %b want 00", dut.pulsos);
        end
        botao = 1'b0;
        step(1);
        checks++;
        if (dut.pulsos !== 2'b10) begin
            errors++;
            $display("FAIL short_a_pulse got %b want 10", dut.pulsos);
        end
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL short_latency got %b want 000", {L, enable, modo_manual});
        end
        step(1);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL short_a_once got %b want 00", dut.pulsos);
        end
        checks++;
        if ({L, enable, modo_manual} !== 3'b110) begin
            errors++;
            $display("FAIL short_on got %b want 110", {L, enable, modo_manual});
        end
        botao = 1'b1;
        step(4);
        botao = 1'b0;
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b110) begin
            errors++;
            $display("FAIL short2_latency got %b want 110", {L, enable, modo_manual});
        end
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL short2_off got %b want 000", {L, enable, modo_manual});
        end
    endtask

    task automatic test_glitch;
        botao = 1'b1;
        step(1);
        botao = 1'b0;
        step(1);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL glitch_pulse got %b want 00", dut.pulsos);
        end
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_state got %b want 000", {L, enable, modo_manual});
        end
    endtask

    task automatic test_long_press;
        botao = 1'b1;
        step(7);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL long_early got %b want 00", dut.pulsos);
        end
        step(1);
        checks++;
        if (dut.pulsos !== 2'b01) begin
            errors++;
            $display("FAIL long_b_pulse got %b want 01", dut.pulsos);
        end
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL long_latency got %b want 000", {L, enable, modo_manual});
        end
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b101) begin
            errors++;
            $display("FAIL long_manual got %b want 101", {L, enable, modo_manual});
        end
        step(3);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL long_saturate got %b want 00", dut.pulsos);
        end
        botao = 1'b0;
        step(1);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL long_release got %b want 00", dut.pulsos);
        end
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b101) begin
            errors++;
            $display("FAIL long_hold got %b want 101", {L, enable, modo_manual});
        end
        C = 1'b1;
        step(1);
        C = 1'b0;
        checks++;
        if ({L, enable, modo_manual} !== 3'b101) begin
            errors++;
            $display("FAIL manual_c got %b want 101", {L, enable, modo_manual});
        end
        botao = 1'b1;
        step(3);
        botao = 1'b0;
        step(2);
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL manual_short_off got %b want 000", {L, enable, modo_manual});
        end
    endtask

    task automatic test_timeout_presence;
        infravermelho = 1'b1;
        step(1);
        infravermelho = 1'b0;
        checks++;
        if ({L, enable, modo_manual} !== 3'b110) begin
            errors++;
            $display("FAIL ir_on got %b want 110", {L, enable, modo_manual});
        end
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b110) begin
            errors++;
            $display("FAIL auto_hold got %b want 110", {L, enable, modo_manual});
        end
        C = 1'b1;
        step(1);
        C = 1'b0;
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL c_off got %b want 000", {L, enable, modo_manual});
        end
        infravermelho = 1'b1;
        step(1);
        infravermelho = 1'b0;
        checks++;
        if ({L, enable, modo_manual} !== 3'b110) begin
            errors++;
            $display("FAIL ir_reon got %b want 110", {L, enable, modo_manual});
        end
    endtask

    task automatic test_back_to_back;
        botao = 1'b1;
        step(8);
        checks++;
        if (dut.pulsos !== 2'b01) begin
            errors++;
            $display("FAIL bc_b_pulse got %b want 01", dut.pulsos);
        end
        C = 1'b1;
        step(1);
        C = 1'b0;
        checks++;
        if ({L, enable, modo_manual} !== 3'b101) begin
            errors++;
            $display("FAIL b_with_c got %b want 101", {L, enable, modo_manual});
        end
        botao = 1'b0;
        step(1);
        botao = 1'b1;
        step(5);
        checks++;
        if (dut.u_classificador.tp !== 4'd5) begin
            errors++;
            $display("FAIL tp_mid got %0d want 5", dut.u_classificador.tp);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if ({L, enable, modo_manual} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got %b want 000", {L, enable, modo_manual});
        end
        step(7);
        checks++;
        if (dut.pulsos !== 2'b00) begin
            errors++;
            $display("FAIL fresh_early got %b want 00", dut.pulsos);
        end
        step(1);
        checks++;
        if (dut.pulsos !== 2'b01) begin
            errors++;
            $display("FAIL fresh_b got %b want 01", dut.pulsos);
        end
        step(1);
        checks++;
        if ({L, enable, modo_manual} !== 3'b101) begin
            errors++;
            $display("FAIL fresh_manual got %b want 101", {L, enable, modo_manual});
        end
        botao = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_glitch();
        test_long_press();
        test_timeout_presence();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
